// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: bubble encoding,
// control-bundle field positions and the per-edge stage action.
package pipe_pkg;

    localparam int          PIPE_CTRL_W    = 24;
    localparam logic [15:0] PIPE_NOP_INSTR = 16'h0800;

    // Field positions inside the packed control bundle from the control block.
    localparam int CTRL_LOAD_BIT   = 0;
    localparam int CTRL_MEMWRT_BIT = 1;
    localparam int CTRL_REGWRT_BIT = 2;
    localparam int CTRL_BRANCH_BIT = 3;
    localparam int CTRL_JUMP_BIT   = 4;
    localparam int CTRL_HALT_BIT   = 5;

    typedef enum logic [2:0] {
        ACT_RST,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } stage_act_e;

    // Priority order: reset, flush, hold, bubble, load.
    function automatic stage_act_e pick_action(
        input logic rst_n,
        input logic flush,
        input logic hold,
        input logic bubble
    );
        if (!rst_n)
            return ACT_RST;
        else if (flush)
            return ACT_FLUSH;
        else if (hold)
            return ACT_HOLD;
        else if (bubble)
            return ACT_BUBBLE;
        else
            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/load_use_tracker.sv
// Load-use hazard detector: remembers destinations of the last LOAD_LAT issued
// loads and flags a decode instruction that reads one of them.
module load_use_tracker
    import pipe_pkg::*;
#(
    parameter int REG_SEL_W = 3,
    parameter int LOAD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic                 is_load,
    input  logic [REG_SEL_W-1:0] wr_reg_in,
    input  logic [REG_SEL_W-1:0] rs1_sel,
    input  logic [REG_SEL_W-1:0] rs2_sel,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    input  logic                 mem_stall,
    input  logic                 do_branch,
    output logic                 haz_stall
);

    logic [LOAD_LAT-1:0]  ent_v;
    logic [REG_SEL_W-1:0] ent_rd [LOAD_LAT];
    logic                 hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (ent_v[i] &&
                ((uses_rs1 && (ent_rd[i] == rs1_sel)) ||
                 (uses_rs2 && (ent_rd[i] == rs2_sel))))
                hit = 1'b1;
        end
    end

    // Register 0 is a real register here, so no zero-select exemption.
    assign haz_stall = rst & valid_in & ~do_branch & hit;

    always_ff @(posedge clk) begin
        if (!rst || do_branch) begin
            ent_v <= '0;
            for (int i = 0; i < LOAD_LAT; i++)
                ent_rd[i] <= '0;
        end else if (!mem_stall) begin
            for (int i = LOAD_LAT - 1; i > 0; i--) begin
                ent_v[i]  <= ent_v[i-1];
                ent_rd[i] <= ent_rd[i-1];
            end
            // A stalled instruction is not issued, so it must not be tracked.
            ent_v[0]  <= valid_in & is_load & ~haz_stall;
            ent_rd[0] <= wr_reg_in;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline boundary register with hold, flush, bubble and load-use stall.
// Define ID_EX_PERF_EN to add saturating bubble/flush event counters.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W   = 16,
    parameter int PC_W      = 16,
    parameter int DATA_W    = 16,
    parameter int CTRL_W    = PIPE_CTRL_W,
    parameter int REG_SEL_W = 3,
    parameter int LOAD_BIT  = CTRL_LOAD_BIT,
    parameter int LOAD_LAT  = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [INSTR_W-1:0]   instr_in,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic [REG_SEL_W-1:0] wr_reg_in,
    input  logic [REG_SEL_W-1:0] rs1_sel,
    input  logic [REG_SEL_W-1:0] rs2_sel,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    input  logic [DATA_W-1:0]    rs1_data,
    input  logic [DATA_W-1:0]    rs2_data,
    input  logic                 mem_stall,
    input  logic                 do_branch,
    output logic                 haz_stall,
    output logic                 valid_out,
    output logic [INSTR_W-1:0]   instr_out,
    output logic [PC_W-1:0]      pc_out,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [REG_SEL_W-1:0] wr_reg_out,
    output logic [DATA_W-1:0]    rs1_out,
    output logic [DATA_W-1:0]    rs2_out
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]          bubble_cnt,
    output logic [15:0]          flush_cnt
`endif
);

    stage_act_e act;

    load_use_tracker #(
        .REG_SEL_W (REG_SEL_W),
        .LOAD_LAT  (LOAD_LAT)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .is_load   (ctrl_in[LOAD_BIT]),
        .wr_reg_in (wr_reg_in),
        .rs1_sel   (rs1_sel),
        .rs2_sel   (rs2_sel),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .mem_stall (mem_stall),
        .do_branch (do_branch),
        .haz_stall (haz_stall)
    );

    always_comb act = pick_action(rst, do_branch, mem_stall, haz_stall);

    always_ff @(posedge clk) begin
        unique case (act)
            ACT_RST, ACT_FLUSH, ACT_BUBBLE: begin
                valid_out  <= 1'b0;
                instr_out  <= NOP_INSTR;
                pc_out     <= '0;
                ctrl_out   <= '0;
                wr_reg_out <= '0;
                rs1_out    <= '0;
                rs2_out    <= '0;
            end
            ACT_HOLD: begin
            end
            ACT_LOAD: begin
                valid_out  <= valid_in;
                instr_out  <= valid_in ? instr_in : NOP_INSTR;
                ctrl_out   <= valid_in ? ctrl_in : '0;
                pc_out     <= pc_in;
                wr_reg_out <= wr_reg_in;
                rs1_out    <= rs1_data;
                rs2_out    <= rs2_data;
            end
        endcase
    end

`ifdef ID_EX_PERF_EN
    // Flushes of an empty stage and empty decode are not worth counting.
    always_ff @(posedge clk) begin
        if (act == ACT_RST) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if ((act == ACT_BUBBLE) && (bubble_cnt != 16'hFFFF))
                bubble_cnt <= bubble_cnt + 16'd1;
            if ((act == ACT_FLUSH) && (valid_out || valid_in) && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: LOAD_LAT=1 and LOAD_LAT=2 instances on shared stimulus,
// checked against a per-register availability-countdown scoreboard.
module tb_id_ex_pipe_reg;

    localparam logic [23:0] LD  = 24'h000001;
    localparam logic [23:0] ALU = 24'h000104;
    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [23:0] ctrl;
        logic [2:0]  wr;
        logic [15:0] rs1;
        logic [15:0] rs2;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, valid_in, uses_rs1, uses_rs2, mem_stall, do_branch;
    logic [15:0] instr_in, pc_in, rs1_data, rs2_data;
    logic [23:0] ctrl_in;
    logic [2:0]  wr_reg_in, rs1_sel, rs2_sel;

    logic        haz [2];
    logic        vo  [2];
    logic [15:0] io  [2];
    logic [15:0] po  [2];
    logic [23:0] co  [2];
    logic [2:0]  wo  [2];
    logic [15:0] r1o [2];
    logic [15:0] r2o [2];
`ifdef ID_EX_PERF_EN
    logic [15:0] bc  [2];
    logic [15:0] fc  [2];
`endif

    out_t        exp_q0[$];
    out_t        exp_q1[$];
    out_t        m_out [2];
    int          m_cnt [2][8];
    logic [15:0] m_bub [2];
    logic [15:0] m_fl  [2];
    int          lat   [2] = '{1, 2};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.LOAD_LAT(1)) u_dut1 (
        .clk(clk),
`ifdef ID_EX_PERF_EN
        .bubble_cnt(bc[0]), .flush_cnt(fc[0]),
`endif
        .rst(rst), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .wr_reg_in(wr_reg_in), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mem_stall(mem_stall), .do_branch(do_branch), .haz_stall(haz[0]),
        .valid_out(vo[0]), .instr_out(io[0]), .pc_out(po[0]), .ctrl_out(co[0]),
        .wr_reg_out(wo[0]), .rs1_out(r1o[0]), .rs2_out(r2o[0])
    );

    id_ex_pipe_reg #(.LOAD_LAT(2)) u_dut2 (
        .clk(clk),
`ifdef ID_EX_PERF_EN
        .bubble_cnt(bc[1]), .flush_cnt(fc[1]),
`endif
        .rst(rst), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .wr_reg_in(wr_reg_in), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mem_stall(mem_stall), .do_branch(do_branch), .haz_stall(haz[1]),
        .valid_out(vo[1]), .instr_out(io[1]), .pc_out(po[1]), .ctrl_out(co[1]),
        .wr_reg_out(wo[1]), .rs1_out(r1o[1]), .rs2_out(r2o[1])
    );

    task automatic chk_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic out_t bubble_out();
        out_t b;
        b       = '0;
        b.instr = NOP;
        return b;
    endfunction

    function automatic logic model_haz(input int d);
        logic dep;
        dep = (uses_rs1 && m_cnt[d][rs1_sel] > 0) || (uses_rs2 && m_cnt[d][rs2_sel] > 0);
        return rst && valid_in && !do_branch && dep;
    endfunction

    // Each register carries a countdown of issue cycles until its load result is usable.
    task automatic model_edge(input int d, input logic h);
        out_t cap;
        if (!rst) begin
            m_out[d] = bubble_out();
            for (int r = 0; r < 8; r++) m_cnt[d][r] = 0;
            m_bub[d] = '0;
            m_fl[d]  = '0;
        end else if (do_branch) begin
            if ((m_out[d].valid || valid_in) && m_fl[d] != 16'hFFFF) m_fl[d]++;
            m_out[d] = bubble_out();
            for (int r = 0; r < 8; r++) m_cnt[d][r] = 0;
        end else if (!mem_stall) begin
            for (int r = 0; r < 8; r++) if (m_cnt[d][r] > 0) m_cnt[d][r]--;
            if (h) begin
                m_out[d] = bubble_out();
                if (m_bub[d] != 16'hFFFF) m_bub[d]++;
            end else begin
                cap.valid = valid_in;
                cap.instr = valid_in ? instr_in : NOP;
                cap.ctrl  = valid_in ? ctrl_in : 24'h0;
                cap.pc    = pc_in;
                cap.wr    = wr_reg_in;
                cap.rs1   = rs1_data;
                cap.rs2   = rs2_data;
                m_out[d]  = cap;
                if (valid_in && ctrl_in[0]) m_cnt[d][wr_reg_in] = lat[d];
            end
        end
    endtask

    task automatic step(input logic s_rst, input logic v, input logic [23:0] ctrl,
                        input logic [2:0] wr, input logic [2:0] r1, input logic [2:0] r2,
                        input logic u1, input logic u2, input logic ms, input logic br);
        logic h [2];
        out_t got, want;
        @(negedge clk);
        rst       = s_rst;
        valid_in  = v;
        ctrl_in   = ctrl;
        wr_reg_in = wr;
        rs1_sel   = r1;
        rs2_sel   = r2;
        uses_rs1  = u1;
        uses_rs2  = u2;
        mem_stall = ms;
        do_branch = br;
        instr_in  = 16'($urandom);
        pc_in     = 16'($urandom);
        rs1_data  = 16'($urandom);
        rs2_data  = 16'($urandom);
        #1;
        for (int d = 0; d < 2; d++) begin
            h[d] = model_haz(d);
            chk_val($sformatf("haz_stall[lat%0d]", lat[d]), 96'(haz[d]), 96'(h[d]));
        end
        for (int d = 0; d < 2; d++) model_edge(d, h[d]);
        exp_q0.push_back(m_out[0]);
        exp_q1.push_back(m_out[1]);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            got  = {vo[d], io[d], po[d], co[d], wo[d], r1o[d], r2o[d]};
            want = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk_val($sformatf("stage_out[lat%0d]", lat[d]), 96'(got), 96'(want));
`ifdef ID_EX_PERF_EN
            chk_val($sformatf("bubble_cnt[lat%0d]", lat[d]), 96'(bc[d]), 96'(m_bub[d]));
            chk_val($sformatf("flush_cnt[lat%0d]", lat[d]), 96'(fc[d]), 96'(m_fl[d]));
`endif
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_out[d] = bubble_out();
            m_bub[d] = '0;
            m_fl[d]  = '0;
            for (int r = 0; r < 8; r++) m_cnt[d][r] = 0;
        end
        rst = 1'b0; valid_in = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
        mem_stall = 1'b0; do_branch = 1'b0; instr_in = '0; pc_in = '0;
        rs1_data = '0; rs2_data = '0; ctrl_in = '0; wr_reg_in = '0;
        rs1_sel = '0; rs2_sel = '0;

        // reset, then idle decode
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, LD, 1, 1, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, LD, 2, 0, 0, 0, 0, 0, 0);

        // load r3, dependent add reads r3 through rs2 and is held upstream
        step(1, 1, LD, 3, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, ALU, 4, 1, 3, 1, 1, 0, 0);

        // load r5, dependent via rs1; then same selects with no source use
        step(1, 1, LD, 5, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, ALU, 6, 5, 1, 1, 0, 0, 0);
        step(1, 1, LD, 5, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, ALU, 6, 5, 5, 0, 0, 0, 0);

        // register 0 is tracked like any other
        step(1, 1, LD, 0, 1, 1, 0, 0, 0, 0);
        repeat (3) step(1, 1, ALU, 2, 0, 1, 1, 1, 0, 0);

        // load r2, dependent waits through a 3-cycle memory stall
        step(1, 1, LD, 2, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, ALU, 3, 2, 2, 1, 0, 1, 0);
        repeat (3) step(1, 1, ALU, 3, 2, 2, 1, 0, 0, 0);

        // flush wins over stall and empties the tracker
        step(1, 1, LD, 6, 0, 0, 0, 0, 0, 0);
        step(1, 1, LD, 6, 6, 6, 1, 1, 1, 1);
        repeat (2) step(1, 1, ALU, 1, 6, 6, 1, 1, 0, 0);

        // reset while a load-use stall is pending
        step(1, 1, LD, 7, 0, 0, 0, 0, 0, 0);
        step(0, 1, ALU, 1, 7, 7, 1, 1, 0, 0);
        step(1, 1, ALU, 1, 7, 7, 1, 1, 0, 0);

        // random traffic over a small register set to provoke frequent hazards
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom),
                 {23'($urandom), 1'($urandom)},
                 3'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
